// File: rtl/commit_trace_buffer.sv
// Purpose : queues one retire record per cycle from the Wr stage and drains it over a valid/ready trace port.
// Latency : a record pushed into an empty buffer is presented on out_* after the next clock edge (no bypass).
// Backpres: out_* hold while out_valid && !out_ready; near_full asks the pipeline to stall; overflow drops are counted.
//
// Ports:
//   clk, rst (async, active-low)  trace_en, clear (sync flush)
//   cm_*      : commit record from the write-back stage
//   out_*     : registered head record, out_valid/out_ready handshake
//   level, near_full, drop_cnt, conflict_err : status
module commit_trace_buffer #(
   parameter int DEPTH    = 16,
   parameter int HEADROOM = 2,
   parameter int STAMP_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     trace_en,
   input  logic                     clear,
   input  logic                     cm_valid,
   input  logic [31:0]              cm_pc,
   input  logic                     cm_rf_we,
   input  logic [4:0]               cm_rf_addr,
   input  logic [31:0]              cm_rf_data,
   input  logic                     cm_dm_we,
   input  logic [31:0]              cm_dm_addr,
   input  logic [31:0]              cm_dm_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [STAMP_W-1:0]       out_stamp,
   output logic [31:0]              out_pc,
   output logic [1:0]               out_kind,
   output logic [31:0]              out_addr,
   output logic [31:0]              out_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     near_full,
   output logic [15:0]              drop_cnt,
   output logic                     conflict_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] NF_LVL = LW'(DEPTH - HEADROOM);

   typedef struct packed {
      logic [STAMP_W-1:0] stamp;
      logic [31:0]        pc;
      logic [1:0]         kind;
      logic [31:0]        addr;
      logic [31:0]        data;
   } rec_t;

   rec_t               mem [DEPTH];
   rec_t               new_rec;
   rec_t               head_rec;
   rec_t               out_q;
   logic [STAMP_W-1:0] stamp;
   logic [LW-1:0]      wr_ptr, rd_ptr;
   logic [LW-1:0]      wr_ptr_n, rd_ptr_n, level_n;
   logic               push, pop, full, push_ok, drop, rf_eff;

   assign push    = cm_valid && trace_en && !clear;
   assign pop     = out_valid && out_ready;
   assign full    = (level == LW'(DEPTH));
   // A full buffer still accepts when the head leaves in the same cycle.
   assign push_ok = push && (!full || pop);
   assign drop    = push && full && !pop;
   // A write to $0 has no architectural effect.
   assign rf_eff  = cm_rf_we && (cm_rf_addr != 5'd0);

   assign wr_ptr_n = wr_ptr + LW'(push_ok);
   assign rd_ptr_n = rd_ptr + LW'(pop);
   assign level_n  = level + LW'(push_ok) - LW'(pop);

   always_comb begin
      new_rec       = '0;
      new_rec.stamp = stamp;
      new_rec.pc    = cm_pc;
      if (rf_eff) begin
         new_rec.kind = 2'd1;
         new_rec.addr = {27'd0, cm_rf_addr};
         new_rec.data = cm_rf_data;
      end else if (cm_dm_we) begin
         new_rec.kind = 2'd2;
         new_rec.addr = cm_dm_addr;
         new_rec.data = cm_dm_data;
      end
   end

   // When nothing older remains after this cycle's pop, the new head is the
   // record being written right now, so take it straight from the input.
   always_comb begin
      if (rd_ptr_n == wr_ptr)
         head_rec = new_rec;
      else
         head_rec = mem[rd_ptr_n[AW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr[AW-1:0]] <= new_rec;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stamp        <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         level        <= '0;
         near_full    <= 1'b0;
         drop_cnt     <= '0;
         conflict_err <= 1'b0;
         out_valid    <= 1'b0;
         out_q        <= '0;
      end else if (clear) begin
         stamp        <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         level        <= '0;
         near_full    <= 1'b0;
         drop_cnt     <= '0;
         conflict_err <= 1'b0;
         out_valid    <= 1'b0;
         out_q        <= '0;
      end else begin
         stamp     <= stamp + STAMP_W'(1);
         wr_ptr    <= wr_ptr_n;
         rd_ptr    <= rd_ptr_n;
         level     <= level_n;
         near_full <= (level_n >= NF_LVL);
         if (drop && (drop_cnt != 16'hFFFF))
            drop_cnt <= drop_cnt + 16'd1;
         if (push && rf_eff && cm_dm_we)
            conflict_err <= 1'b1;
         out_valid <= (level_n != '0);
         out_q     <= (level_n != '0) ? head_rec : '0;
      end
   end

   assign out_stamp = out_q.stamp;
   assign out_pc    = out_q.pc;
   assign out_kind  = out_q.kind;
   assign out_addr  = out_q.addr;
   assign out_data  = out_q.data;

endmodule
